lutram_pattern_tester: RTL and testbench
========================================

// Module: lutram_pattern_tester
// PURPOSE
//  Parametrised, self-checking distributed-RAM (LUTRAM) test harness. Next generation of the single-bit
//  128x1 dual-port probe: any depth/width, four data patterns, on-chip readback compare on both ports,
//  error counting and first-fail capture. Sits at top level of a lutram-tests bitstream; outputs go to LEDs/ILA.
// PARAMETERS
//  A_WIDTH    7          address width; RAM depth = 2**A_WIDTH
//  D_WIDTH    1          RAM data width (1..32)
//  STEP_DIV   24'hFFFFFF step tick every STEP_DIV+1 clocks; 0 = every clock
//  ERR_WIDTH  16         width of saturating error counter
// PORTS
//  clk_i             in   1          single clock; all logic incl. RAM write port
//  rst_i             in   1          synchronous, active-high reset
//  start_i           in   1          level/pulse; starts a run, latched until next step tick
//  mode_i            in   2          pattern select, latched at run start
//  inj_en_i          in   1          fault injection enable, latched at run start
//  inj_addr_i        in   A_WIDTH    address whose written data gets bit 0 inverted when inj_en
//  busy_o            out  1          run in progress (CLEAR..READ)
//  done_o            out  1          run finished; held until next start
//  pass_o            out  1          done_o && err_count_o==0
//  err_count_o       out  ERR_WIDTH  mismatching port reads (saturates at all-ones)
//  first_err_addr_o  out  A_WIDTH    address of first mismatch (SPO address)
//  spo_o             out  D_WIDTH    live SPO (read at write address)
//  dpo_o             out  D_WIDTH    live DPO (read at DPRA = ~addr)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, addr 0, tick divider 0, start pending clr. RAM content not cleared.
//  Tick: step pulses one clk_i cycle every STEP_DIV+1 clocks; FSM/addr/RAM write advance only on tick.
//  FSM (on tick): IDLE -pending start-> CLEAR; CLEAR -addr==max-> WRITE; WRITE -addr==max-> READ;
//   READ -addr==max-> FINISH; FINISH -pending start-> CLEAR. Illegal state -> IDLE.
//   Entering CLEAR: addr=0, err_count=0, first_err cleared, done_o=0, mode/inj latched. busy_o=1 CLEAR..READ.
//  addr: increments per tick in CLEAR/WRITE/READ, wraps max->0 on phase change; 0 in IDLE/FINISH.
//  RAM: 2**A_WIDTH x D_WIDTH, sync write (we & tick), async read on SPO(addr) and DPO(~addr).
//   we = tick && state in {CLEAR,WRITE}. CLEAR writes 0; WRITE writes exp(addr) ^ inj where
//   inj = {..,1'b1} iff inj_en && addr==inj_addr.
//  exp(a) per mode: 0 ALT  = {D_WIDTH{a[0]}}; 1 ADDR = a zero-extended/truncated to D_WIDTH;
//   2 CHECK = alternating ..0101 XOR {D_WIDTH{a[0]}}; 3 INVADDR = ~ADDR pattern.
//  Compare (READ, on tick): spo!=exp(addr) counts 1, dpo!=exp(~addr) counts 1 (both may count in same
//   tick: +2); saturate, never wrap. first_err_addr_o loaded on first mismatch of run only.
//  Latency: result of a READ tick visible in err_count_o next clock. done_o rises the clock FINISH entered.
//  start_i during busy ignored (not queued). start_i in FINISH reruns w/o reset.
//  Reset mid-run: immediate return to IDLE; stale RAM data irrelevant since CLEAR rewrites all.
// STRUCTURE
//  lutram_test_pkg: state localparams (IDLE,CLEAR,WRITE,READ,FINISH), mode codes, function exp_data(a,mode).
//  Sub-module tick_gen (STEP_DIV counter -> 1-cycle tick, sync reset). RAM inferred in-block
//  with ram_style="distributed"; no separate clock-divider clock domain.
// TESTING (STEP_DIV=0 unless noted)
//  1 A7/D1 mode0, start pulse -> CLEAR/WRITE/READ each 128 ticks, done after 384, pass=1, err=0.
//  2 A5/D8 modes 1,2,3 back-to-back starts from FINISH -> each pass=1; err reset at each start.
//  3 inj_en=1 inj_addr=5, A7/D1 mode0 -> err=2 (SPO@5, DPO@~122=5), first_err_addr=5, pass=0.
//  4 rst_i pulsed mid-WRITE -> outputs 0, IDLE; next start -> full run pass=1.
//  5 STEP_DIV=3: addr advances every 4 clocks; start pulse between ticks still taken; start while busy ignored.
//  6 ERR_WIDTH=2 forced via inject at addr 0 on checker stress + force -> err saturates at 3, no wrap.

Source files
------------

// File: rtl/lutram_pattern_tester_pkg.sv
// Shared definitions for the LUTRAM pattern tester.
//   - FSM state codes (plain localparams so legacy tools can consume them)
//   - Pattern mode codes
//   - exp_data(): expected RAM word for an address under a given mode, 32 bits wide;
//     callers truncate to their data width.
package lutram_pattern_tester_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StClear  = 3'd1;
    localparam logic [2:0] StWrite  = 3'd2;
    localparam logic [2:0] StRead   = 3'd3;
    localparam logic [2:0] StFinish = 3'd4;

    localparam logic [1:0] ModeAlt     = 2'd0;
    localparam logic [1:0] ModeAddr    = 2'd1;
    localparam logic [1:0] ModeCheck   = 2'd2;
    localparam logic [1:0] ModeInvAddr = 2'd3;

    // a is the zero-extended address; the result is truncated by the caller, so INVADDR
    // also sets data bits above the address width.
    function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [1:0] mode);
        logic [31:0] alt;
        logic [31:0] res;
        alt = {32{a[0]}};
        case (mode)
            ModeAlt:   res = alt;
            ModeAddr:  res = a;
            ModeCheck: res = 32'h5555_5555 ^ alt;
            default:   res = ~a;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lutram_pattern_tester_if.sv
// Control/status bundle of the LUTRAM pattern tester.
//   master: run control (start, mode, fault injection), observes status.
//   slave : the tester itself.
interface lutram_pattern_tester_if #(
    parameter int unsigned A_WIDTH   = 7,
    parameter int unsigned D_WIDTH   = 1,
    parameter int unsigned ERR_WIDTH = 16
);
    logic                 start_i;
    logic [1:0]           mode_i;
    logic                 inj_en_i;
    logic [A_WIDTH-1:0]   inj_addr_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 pass_o;
    logic [ERR_WIDTH-1:0] err_count_o;
    logic [A_WIDTH-1:0]   first_err_addr_o;
    logic [D_WIDTH-1:0]   spo_o;
    logic [D_WIDTH-1:0]   dpo_o;

    modport master (
        output start_i, mode_i, inj_en_i, inj_addr_i,
        input  busy_o, done_o, pass_o, err_count_o, first_err_addr_o, spo_o, dpo_o
    );

    modport slave (
        input  start_i, mode_i, inj_en_i, inj_addr_i,
        output busy_o, done_o, pass_o, err_count_o, first_err_addr_o, spo_o, dpo_o
    );
endinterface

// File: rtl/lutram_pattern_tester_tick_gen.sv
// Step tick generator: tick_o is high for one clk_i cycle every STEP_DIV+1 clocks
// (every clock when STEP_DIV is 0).
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, restarts the period
//   tick_o : one-cycle step pulse
module lutram_pattern_tester_tick_gen #(
    parameter int unsigned STEP_DIV = 32'h00FF_FFFF
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam logic [23:0] Div = STEP_DIV[23:0];

    logic [23:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == Div);

    always_comb begin
        cnt_d = cnt_q + 24'd1;
        if (tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lutram_pattern_tester.sv
// Self-checking distributed-RAM test harness.
// A run clears the whole RAM, writes a mode-dependent pattern, then reads it back on both
// the write-address port (SPO) and the ~addr port (DPO), counting mismatches.
//   clk_i, rst_i : single clock, synchronous active-high reset
//   tst_io       : run control in (start, mode, fault inject), status out (busy, done, pass,
//                  saturating error count, first failing SPO address, live SPO/DPO)
// ERR_WIDTH must be at least 2.
module lutram_pattern_tester
    import lutram_pattern_tester_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 7,
    parameter int unsigned D_WIDTH   = 1,
    parameter int unsigned STEP_DIV  = 32'h00FF_FFFF,
    parameter int unsigned ERR_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    lutram_pattern_tester_if.slave tst_io
);
    localparam logic [A_WIDTH-1:0] AddrMax = '1;

    logic                 tick;
    logic [2:0]           state_q, state_d;
    logic [A_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]           mode_q, mode_d;
    logic                 inj_en_q, inj_en_d;
    logic [A_WIDTH-1:0]   inj_addr_q, inj_addr_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic [A_WIDTH-1:0]   first_q, first_d;
    logic                 first_vld_q, first_vld_d;
    logic                 done_q, done_d;
    logic                 pend_q, pend_d;

    logic                 busy, start_req, last, we;
    logic [A_WIDTH-1:0]   dpra;
    logic [D_WIDTH-1:0]   spo, dpo, exp_spo, exp_dpo, wdata, inj_vec;
    logic                 spo_mis, dpo_mis;
    logic [1:0]           inc;
    logic [ERR_WIDTH:0]   sum;

    (* ram_style = "distributed" *) logic [D_WIDTH-1:0] mem [2**A_WIDTH];

    lutram_pattern_tester_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    assign busy      = (state_q == StClear) || (state_q == StWrite) || (state_q == StRead);
    // A start seen while idle/finished is held until the next tick consumes it.
    assign start_req = pend_q | (tst_io.start_i & ~busy);
    assign last      = (addr_q == AddrMax);
    assign dpra      = ~addr_q;

    assign spo     = mem[addr_q];
    assign dpo     = mem[dpra];
    assign exp_spo = D_WIDTH'(exp_data(32'(addr_q), mode_q));
    assign exp_dpo = D_WIDTH'(exp_data(32'(dpra), mode_q));
    assign spo_mis = (spo != exp_spo);
    assign dpo_mis = (dpo != exp_dpo);
    assign inc     = {1'b0, spo_mis} + {1'b0, dpo_mis};
    assign sum     = {1'b0, err_q} + {{(ERR_WIDTH - 1){1'b0}}, inc};

    always_comb begin
        inj_vec    = '0;
        inj_vec[0] = inj_en_q && (addr_q == inj_addr_q);
    end

    assign we    = tick && ((state_q == StClear) || (state_q == StWrite));
    assign wdata = (state_q == StWrite) ? (exp_spo ^ inj_vec) : '0;

    always_ff @(posedge clk_i) begin
        if (we) mem[addr_q] <= wdata;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        inj_en_d    = inj_en_q;
        inj_addr_d  = inj_addr_q;
        err_d       = err_q;
        first_d     = first_q;
        first_vld_d = first_vld_q;
        done_d      = done_q;
        pend_d      = start_req;
        if (tick) begin
            pend_d = 1'b0;
            addr_d = addr_q + 1'b1;
            case (state_q)
                StIdle, StFinish: begin
                    addr_d = '0;
                    if (start_req) begin
                        state_d     = StClear;
                        err_d       = '0;
                        first_d     = '0;
                        first_vld_d = 1'b0;
                        done_d      = 1'b0;
                        mode_d      = tst_io.mode_i;
                        inj_en_d    = tst_io.inj_en_i;
                        inj_addr_d  = tst_io.inj_addr_i;
                    end
                end
                StClear: if (last) state_d = StWrite;
                StWrite: if (last) state_d = StRead;
                StRead: begin
                    err_d = sum[ERR_WIDTH] ? '1 : sum[ERR_WIDTH-1:0];
                    if ((spo_mis || dpo_mis) && !first_vld_q) begin
                        first_d     = addr_q;
                        first_vld_d = 1'b1;
                    end
                    if (last) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    addr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            mode_q      <= '0;
            inj_en_q    <= 1'b0;
            inj_addr_q  <= '0;
            err_q       <= '0;
            first_q     <= '0;
            first_vld_q <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mode_q      <= mode_d;
            inj_en_q    <= inj_en_d;
            inj_addr_q  <= inj_addr_d;
            err_q       <= err_d;
            first_q     <= first_d;
            first_vld_q <= first_vld_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
        end
    end

    assign tst_io.busy_o           = busy;
    assign tst_io.done_o           = done_q;
    assign tst_io.pass_o           = done_q && (err_q == '0);
    assign tst_io.err_count_o      = err_q;
    assign tst_io.first_err_addr_o = first_q;
    assign tst_io.spo_o            = spo;
    assign tst_io.dpo_o            = dpo;
endmodule

// File: tb/tb_lutram_pattern_tester.sv
// Directed bench for lutram_pattern_tester.
//   u0: A7/D1, every-clock tick   (basic run, fault injection, reset)
//   u1: A5/D8, every-clock tick   (modes back to back)
//   u2: A3/D4, tick every 4 clocks (tick pacing, start handling)
//   u3: A3/D1, 2-bit error counter (saturation)
module tb_lutram_pattern_tester;
    logic clk;
    logic rst0, rst1, rst2, rst3;
    int   n_tests = 0;
    int   n_fail  = 0;

    lutram_pattern_tester_if #(.A_WIDTH(7), .D_WIDTH(1), .ERR_WIDTH(16)) if0 ();
    lutram_pattern_tester_if #(.A_WIDTH(5), .D_WIDTH(8), .ERR_WIDTH(16)) if1 ();
    lutram_pattern_tester_if #(.A_WIDTH(3), .D_WIDTH(4), .ERR_WIDTH(16)) if2 ();
    lutram_pattern_tester_if #(.A_WIDTH(3), .D_WIDTH(1), .ERR_WIDTH(2))  if3 ();

    lutram_pattern_tester #(.A_WIDTH(7), .D_WIDTH(1), .STEP_DIV(0), .ERR_WIDTH(16)) u_dut0 (
        .clk_i (clk), .rst_i (rst0), .tst_io (if0)
    );
    lutram_pattern_tester #(.A_WIDTH(5), .D_WIDTH(8), .STEP_DIV(0), .ERR_WIDTH(16)) u_dut1 (
        .clk_i (clk), .rst_i (rst1), .tst_io (if1)
    );
    lutram_pattern_tester #(.A_WIDTH(3), .D_WIDTH(4), .STEP_DIV(3), .ERR_WIDTH(16)) u_dut2 (
        .clk_i (clk), .rst_i (rst2), .tst_io (if2)
    );
    lutram_pattern_tester #(.A_WIDTH(3), .D_WIDTH(1), .STEP_DIV(0), .ERR_WIDTH(2)) u_dut3 (
        .clk_i (clk), .rst_i (rst3), .tst_io (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        {rst0, rst1, rst2, rst3} = 4'hF;
        if0.start_i = 0; if0.mode_i = 0; if0.inj_en_i = 0; if0.inj_addr_i = 0;
        if1.start_i = 0; if1.mode_i = 0; if1.inj_en_i = 0; if1.inj_addr_i = 0;
        if2.start_i = 0; if2.mode_i = 0; if2.inj_en_i = 0; if2.inj_addr_i = 0;
        if3.start_i = 0; if3.mode_i = 0; if3.inj_en_i = 0; if3.inj_addr_i = 0;
        step(2);
        check("rst_busy",  32'(if0.busy_o), 32'd0);
        check("rst_done",  32'(if0.done_o), 32'd0);
        check("rst_pass",  32'(if0.pass_o), 32'd0);
        check("rst_err",   32'(if0.err_count_o), 32'd0);
        check("rst_first", 32'(if0.first_err_addr_o), 32'd0);
        {rst0, rst1, rst2, rst3} = 4'h0;

        // Test 1: A7/D1 mode ALT, 3 x 128 ticks.
        if0.mode_i = 2'd0; if0.start_i = 1; step(1); if0.start_i = 0;
        check("t1_busy_start", 32'(if0.busy_o), 32'd1);
        step(383);
        check("t1_done_early", 32'(if0.done_o), 32'd0);
        check("t1_busy_late",  32'(if0.busy_o), 32'd1);
        step(1);
        check("t1_done", 32'(if0.done_o), 32'd1);
        check("t1_busy", 32'(if0.busy_o), 32'd0);
        check("t1_pass", 32'(if0.pass_o), 32'd1);
        check("t1_err",  32'(if0.err_count_o), 32'd0);
        check("t1_spo",  32'(if0.spo_o), 32'd0);
        check("t1_dpo",  32'(if0.dpo_o), 32'd1);

        // Test 3: bit flip at address 5 seen on SPO@5 and DPO@122.
        if0.inj_en_i = 1; if0.inj_addr_i = 7'd5; if0.start_i = 1; step(1);
        if0.start_i = 0; if0.inj_en_i = 0;
        check("t3_done_clr", 32'(if0.done_o), 32'd0);
        step(384);
        check("t3_done",  32'(if0.done_o), 32'd1);
        check("t3_err",   32'(if0.err_count_o), 32'd2);
        check("t3_first", 32'(if0.first_err_addr_o), 32'd5);
        check("t3_pass",  32'(if0.pass_o), 32'd0);

        // Test 4: reset from FINISH and mid-WRITE, then a clean run.
        rst0 = 1; step(1); rst0 = 0;
        check("t4_rst_done",  32'(if0.done_o), 32'd0);
        check("t4_rst_err",   32'(if0.err_count_o), 32'd0);
        check("t4_rst_first", 32'(if0.first_err_addr_o), 32'd0);
        if0.start_i = 1; step(1); if0.start_i = 0;
        step(200);
        check("t4_busy_mid", 32'(if0.busy_o), 32'd1);
        rst0 = 1; step(1); rst0 = 0;
        check("t4_busy_rst", 32'(if0.busy_o), 32'd0);
        check("t4_done_rst", 32'(if0.done_o), 32'd0);
        step(5);
        check("t4_idle", 32'(if0.busy_o), 32'd0);
        if0.start_i = 1; step(1); if0.start_i = 0;
        step(384);
        check("t4_pass", 32'(if0.pass_o), 32'd1);
        check("t4_err",  32'(if0.err_count_o), 32'd0);

        // Test 2: A5/D8, injected ADDR run then clean runs in modes 2, 3, 1 from FINISH.
        if1.mode_i = 2'd1; if1.inj_en_i = 1; if1.inj_addr_i = 5'd9;
        if1.start_i = 1; step(1); if1.start_i = 0; if1.inj_en_i = 0;
        step(96);
        check("t2_inj_err",   32'(if1.err_count_o), 32'd2);
        check("t2_inj_first", 32'(if1.first_err_addr_o), 32'd9);
        check("t2_inj_pass",  32'(if1.pass_o), 32'd0);
        if1.mode_i = 2'd2; if1.start_i = 1; step(1); if1.start_i = 0;
        check("t2_err_clr",   32'(if1.err_count_o), 32'd0);
        check("t2_first_clr", 32'(if1.first_err_addr_o), 32'd0);
        check("t2_done_clr",  32'(if1.done_o), 32'd0);
        step(96);
        check("t2_m2_pass", 32'(if1.pass_o), 32'd1);
        check("t2_m2_spo",  32'(if1.spo_o), 32'h55);
        check("t2_m2_dpo",  32'(if1.dpo_o), 32'hAA);
        if1.mode_i = 2'd3; if1.start_i = 1; step(1); if1.start_i = 0;
        step(96);
        check("t2_m3_pass", 32'(if1.pass_o), 32'd1);
        check("t2_m3_spo",  32'(if1.spo_o), 32'hFF);
        check("t2_m3_dpo",  32'(if1.dpo_o), 32'hE0);
        if1.mode_i = 2'd1; if1.start_i = 1; step(1); if1.start_i = 0;
        step(96);
        check("t2_m1_pass", 32'(if1.pass_o), 32'd1);
        check("t2_m1_spo",  32'(if1.spo_o), 32'h00);
        check("t2_m1_dpo",  32'(if1.dpo_o), 32'h1F);

        // Test 5: STEP_DIV=3; ticks land on every 4th clock after reset.
        rst2 = 1; step(1); rst2 = 0;
        if2.mode_i = 2'd2; if2.start_i = 1; step(1); if2.start_i = 0;
        check("t5_wait_tick1", 32'(if2.busy_o), 32'd0);
        step(2);
        check("t5_wait_tick3", 32'(if2.busy_o), 32'd0);
        step(1);
        check("t5_taken", 32'(if2.busy_o), 32'd1);
        step(10); if2.start_i = 1; step(1); if2.start_i = 0;
        check("t5_busy", 32'(if2.busy_o), 32'd1);
        step(84);
        check("t5_done_early", 32'(if2.done_o), 32'd0);
        step(1);
        check("t5_done", 32'(if2.done_o), 32'd1);
        check("t5_pass", 32'(if2.pass_o), 32'd1);
        check("t5_spo",  32'(if2.spo_o), 32'h5);
        check("t5_dpo",  32'(if2.dpo_o), 32'hA);
        step(12);
        check("t5_no_rerun_busy", 32'(if2.busy_o), 32'd0);
        check("t5_no_rerun_done", 32'(if2.done_o), 32'd1);

        // Test 6: SPO forced high plus injection at 0 gives 5 mismatches into a 2-bit counter.
        force u_dut3.spo = 1'b1;
        if3.mode_i = 2'd0; if3.inj_en_i = 1; if3.inj_addr_i = 3'd0;
        if3.start_i = 1; step(1); if3.start_i = 0;
        step(24);
        check("t6_done",  32'(if3.done_o), 32'd1);
        check("t6_err",   32'(if3.err_count_o), 32'd3);
        check("t6_first", 32'(if3.first_err_addr_o), 32'd0);
        check("t6_pass",  32'(if3.pass_o), 32'd0);
        release u_dut3.spo;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
